// File: rtl/alu_issue_scheduler_if.sv
// rtl/alu_issue_scheduler_if.sv - dispatch, CDB and issue signal bundle for alu_issue_scheduler
interface alu_issue_scheduler_if #(
  parameter int size  = 8,
  parameter int tag_w = 4
);
  localparam int occ_w = $clog2(size) + 1;

  logic             flush;

  logic             disp_valid;
  logic             disp_ready;
  logic [2:0]       disp_op;
  logic [tag_w-1:0] disp_tag;
  logic             disp_v1;
  logic             disp_v2;
  logic [31:0]      disp_r1;
  logic [31:0]      disp_r2;
  logic [tag_w-1:0] disp_q1;
  logic [tag_w-1:0] disp_q2;

  logic             cdb_valid;
  logic [tag_w-1:0] cdb_tag;
  logic [31:0]      cdb_data;

  logic             issue_valid;
  logic             issue_ready;
  logic [2:0]       issue_op;
  logic [31:0]      issue_r1;
  logic [31:0]      issue_r2;
  logic [tag_w-1:0] issue_tag;

  logic [occ_w-1:0] occupancy;

  modport master (
    output flush,
    output disp_valid, disp_op, disp_tag, disp_v1, disp_v2,
    output disp_r1, disp_r2, disp_q1, disp_q2,
    output cdb_valid, cdb_tag, cdb_data,
    output issue_ready,
    input  disp_ready,
    input  issue_valid, issue_op, issue_r1, issue_r2, issue_tag,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_op, disp_tag, disp_v1, disp_v2,
    input  disp_r1, disp_r2, disp_q1, disp_q2,
    input  cdb_valid, cdb_tag, cdb_data,
    input  issue_ready,
    output disp_ready,
    output issue_valid, issue_op, issue_r1, issue_r2, issue_tag,
    output occupancy
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - reservation station with CDB wakeup and round-robin issue to the ALU
module alu_issue_scheduler #(
  parameter int size  = 8,
  parameter int tag_w = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_issue_scheduler_if.slave  bus
);
  localparam int idx_w = $clog2(size);
  localparam int occ_w = idx_w + 1;
  localparam logic [occ_w-1:0] full_cnt = occ_w'(size);

  logic [size-1:0]  busy_q;
  logic [2:0]       op_q  [size];
  logic [tag_w-1:0] tag_q [size];
  logic [size-1:0]  v1_q;
  logic [size-1:0]  v2_q;
  logic [31:0]      r1_q  [size];
  logic [31:0]      r2_q  [size];
  logic [tag_w-1:0] q1_q  [size];
  logic [tag_w-1:0] q2_q  [size];

  logic [idx_w-1:0] ptr_q;
  logic [occ_w-1:0] occ_q;
  logic [occ_w-1:0] occ_d;

  logic             issue_valid_q;
  logic [2:0]       issue_op_q;
  logic [31:0]      issue_r1_q;
  logic [31:0]      issue_r2_q;
  logic [tag_w-1:0] issue_tag_q;

  logic [size-1:0]  ready;
  logic [idx_w-1:0] free_idx;
  logic             free_found;
  logic [idx_w-1:0] grant_idx;
  logic             grant_found;
  logic [idx_w-1:0] cand;
  logic             disp_ready;
  logic             disp_acc;
  logic             issue_load;
  logic             do_grant;
  logic             d_v1;
  logic             d_v2;
  logic [31:0]      d_r1;
  logic [31:0]      d_r2;

  // Select looks only at registered operand state; CDB results reach select one edge later.
  always_comb begin
    ready = '0;
    for (int i = 0; i < size; i++) begin
      ready[i] = busy_q[i] & v1_q[i] & v2_q[i];
    end
  end

  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < size; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = idx_w'(i);
      end
    end
  end

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < size; k++) begin
      cand = ptr_q + idx_w'(k);
      if (!grant_found && ready[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign disp_ready = (occ_q < full_cnt);
  assign disp_acc   = bus.disp_valid & disp_ready;
  assign issue_load = !issue_valid_q | bus.issue_ready;
  assign do_grant   = issue_load & grant_found;
  assign occ_d      = occ_q + occ_w'(disp_acc) - occ_w'(do_grant);

  // Incoming operands also capture a same-cycle broadcast so they never miss their producer.
  assign d_v1 = bus.disp_v1 | (bus.cdb_valid & (bus.disp_q1 == bus.cdb_tag));
  assign d_v2 = bus.disp_v2 | (bus.cdb_valid & (bus.disp_q2 == bus.cdb_tag));
  assign d_r1 = bus.disp_v1 ? bus.disp_r1 : bus.cdb_data;
  assign d_r2 = bus.disp_v2 ? bus.disp_r2 : bus.cdb_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q        <= '0;
      ptr_q         <= '0;
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_r1_q    <= '0;
      issue_r2_q    <= '0;
      issue_tag_q   <= '0;
    end else if (bus.flush) begin
      busy_q        <= '0;
      ptr_q         <= '0;
      occ_q         <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < size; i++) begin
        if (bus.cdb_valid && busy_q[i]) begin
          if (!v1_q[i] && (q1_q[i] == bus.cdb_tag)) begin
            v1_q[i] <= 1'b1;
            r1_q[i] <= bus.cdb_data;
          end
          if (!v2_q[i] && (q2_q[i] == bus.cdb_tag)) begin
            v2_q[i] <= 1'b1;
            r2_q[i] <= bus.cdb_data;
          end
        end
      end

      if (disp_acc) begin
        busy_q[free_idx] <= 1'b1;
        op_q[free_idx]   <= bus.disp_op;
        tag_q[free_idx]  <= bus.disp_tag;
        v1_q[free_idx]   <= d_v1;
        v2_q[free_idx]   <= d_v2;
        r1_q[free_idx]   <= d_r1;
        r2_q[free_idx]   <= d_r2;
        q1_q[free_idx]   <= bus.disp_q1;
        q2_q[free_idx]   <= bus.disp_q2;
      end

      if (issue_load) begin
        issue_valid_q <= grant_found;
        if (grant_found) begin
          issue_op_q        <= op_q[grant_idx];
          issue_r1_q        <= r1_q[grant_idx];
          issue_r2_q        <= r2_q[grant_idx];
          issue_tag_q       <= tag_q[grant_idx];
          busy_q[grant_idx] <= 1'b0;
          ptr_q             <= grant_idx + idx_w'(1);
        end
      end

      occ_q <= occ_d;
    end
  end

  assign bus.disp_ready  = disp_ready;
  assign bus.occupancy   = occ_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_op    = issue_op_q;
  assign bus.issue_r1    = issue_r1_q;
  assign bus.issue_r2    = issue_r2_q;
  assign bus.issue_tag   = issue_tag_q;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb/tb_alu_issue_scheduler.sv - directed and random checks of alu_issue_scheduler against a reference model
module tb_alu_issue_scheduler;
  localparam int SIZE  = 8;
  localparam int TAG_W = 4;
  localparam logic [2:0] ALU_ADD = 3'd0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_issue_scheduler_if #(.size(SIZE), .tag_w(TAG_W)) bus ();
  alu_issue_scheduler #(.size(SIZE), .tag_w(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit             busy;
    bit [2:0]       op;
    bit [TAG_W-1:0] tag;
    bit             v1, v2;
    bit [31:0]      r1, r2;
    bit [TAG_W-1:0] q1, q2;
  } ent_t;

  ent_t           m_rs [SIZE];
  int             m_ptr;
  bit             m_iv;
  bit [2:0]       m_op;
  bit [31:0]      m_r1, m_r2;
  bit [TAG_W-1:0] m_tag;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < SIZE; i++) if (m_rs[i].busy) n++;
    return n;
  endfunction

  task automatic model_step();
    int fr, g, idx;
    bit acc, ld;
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) m_rs[i].busy = 0;
      m_ptr = 0; m_iv = 0; m_op = 0; m_r1 = 0; m_r2 = 0; m_tag = 0;
      return;
    end
    if (bus.flush) begin
      for (int i = 0; i < SIZE; i++) m_rs[i].busy = 0;
      m_ptr = 0; m_iv = 0;
      return;
    end
    acc = bus.disp_valid && (m_count() < SIZE);
    fr = -1;
    for (int i = 0; i < SIZE; i++) if (!m_rs[i].busy && fr < 0) fr = i;
    ld = !m_iv || bus.issue_ready;
    g = -1;
    for (int k = 0; k < SIZE; k++) begin
      idx = (m_ptr + k) % SIZE;
      if (g < 0 && m_rs[idx].busy && m_rs[idx].v1 && m_rs[idx].v2) g = idx;
    end
    if (bus.cdb_valid) begin
      for (int i = 0; i < SIZE; i++) begin
        if (m_rs[i].busy && !m_rs[i].v1 && m_rs[i].q1 == bus.cdb_tag) begin
          m_rs[i].v1 = 1; m_rs[i].r1 = bus.cdb_data;
        end
        if (m_rs[i].busy && !m_rs[i].v2 && m_rs[i].q2 == bus.cdb_tag) begin
          m_rs[i].v2 = 1; m_rs[i].r2 = bus.cdb_data;
        end
      end
    end
    if (acc) begin
      m_rs[fr].busy = 1;
      m_rs[fr].op   = bus.disp_op;
      m_rs[fr].tag  = bus.disp_tag;
      m_rs[fr].q1   = bus.disp_q1;
      m_rs[fr].q2   = bus.disp_q2;
      if (bus.disp_v1) begin m_rs[fr].v1 = 1; m_rs[fr].r1 = bus.disp_r1; end
      else if (bus.cdb_valid && bus.disp_q1 == bus.cdb_tag) begin m_rs[fr].v1 = 1; m_rs[fr].r1 = bus.cdb_data; end
      else m_rs[fr].v1 = 0;
      if (bus.disp_v2) begin m_rs[fr].v2 = 1; m_rs[fr].r2 = bus.disp_r2; end
      else if (bus.cdb_valid && bus.disp_q2 == bus.cdb_tag) begin m_rs[fr].v2 = 1; m_rs[fr].r2 = bus.cdb_data; end
      else m_rs[fr].v2 = 0;
    end
    if (ld) begin
      if (g >= 0) begin
        m_iv = 1; m_op = m_rs[g].op; m_r1 = m_rs[g].r1; m_r2 = m_rs[g].r2; m_tag = m_rs[g].tag;
        m_rs[g].busy = 0;
        m_ptr = (g + 1) % SIZE;
      end else begin
        m_iv = 0;
      end
    end
  endtask

  task automatic compare_all();
    int n = m_count();
    check_val("occupancy", 32'(bus.occupancy), n);
    check_val("disp_ready", 32'(bus.disp_ready), 32'(n < SIZE));
    check_val("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
    if (m_iv) begin
      check_val("issue_op", 32'(bus.issue_op), 32'(m_op));
      check_val("issue_r1", bus.issue_r1, m_r1);
      check_val("issue_r2", bus.issue_r2, m_r2);
      check_val("issue_tag", 32'(bus.issue_tag), 32'(m_tag));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_disp(input logic [2:0] op, input logic [3:0] tag,
                          input logic v1, input logic [31:0] r1, input logic [3:0] q1,
                          input logic v2, input logic [31:0] r2, input logic [3:0] q2);
    bus.disp_valid = 1'b1;
    bus.disp_op = op; bus.disp_tag = tag;
    bus.disp_v1 = v1; bus.disp_r1 = r1; bus.disp_q1 = q1;
    bus.disp_v2 = v2; bus.disp_r2 = r2; bus.disp_q2 = q2;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_iv"},   32'(bus.issue_valid), 0);
    check_val({pfx, "_op"},   32'(bus.issue_op), 0);
    check_val({pfx, "_r1"},   bus.issue_r1, 0);
    check_val({pfx, "_r2"},   bus.issue_r2, 0);
    check_val({pfx, "_tag"},  32'(bus.issue_tag), 0);
    check_val({pfx, "_occ"},  32'(bus.occupancy), 0);
    check_val({pfx, "_drdy"}, 32'(bus.disp_ready), 1);
  endtask

  initial begin
    bus.flush = 0; bus.disp_valid = 0; bus.disp_op = 0; bus.disp_tag = 0;
    bus.disp_v1 = 0; bus.disp_v2 = 0; bus.disp_r1 = 0; bus.disp_r2 = 0;
    bus.disp_q1 = 0; bus.disp_q2 = 0; bus.cdb_valid = 0; bus.cdb_tag = 0;
    bus.cdb_data = 0; bus.issue_ready = 0;
    rst = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b1;

    // basic issue
    bus.issue_ready = 1'b1;
    set_disp(ALU_ADD, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    step();
    idle();
    step();
    check_val("basic_iv", 32'(bus.issue_valid), 1);
    check_val("basic_tag", 32'(bus.issue_tag), 3);
    check_val("basic_r1", bus.issue_r1, 5);
    check_val("basic_r2", bus.issue_r2, 7);
    check_val("basic_occ", 32'(bus.occupancy), 0);
    step();

    // CDB wakeup two cycles after dispatch
    set_disp(3'd1, 4'd2, 1'b0, 32'd0, 4'd9, 1'b1, 32'h22, 4'd0);
    step();
    idle();
    step();
    set_cdb(4'd9, 32'hDEADBEEF);
    step();
    idle();
    step();
    check_val("wake_iv", 32'(bus.issue_valid), 1);
    check_val("wake_r1", bus.issue_r1, 32'hDEADBEEF);
    check_val("wake_tag", 32'(bus.issue_tag), 2);
    step();

    // CDB broadcast in the dispatch cycle
    set_disp(3'd1, 4'd2, 1'b0, 32'd0, 4'd9, 1'b1, 32'h22, 4'd0);
    set_cdb(4'd9, 32'hDEADBEEF);
    step();
    idle();
    step();
    check_val("same_iv", 32'(bus.issue_valid), 1);
    check_val("same_r1", bus.issue_r1, 32'hDEADBEEF);
    check_val("same_tag", 32'(bus.issue_tag), 2);
    step();

    // fill all entries, probe full, then round-robin drain in entry order
    do_flush();
    for (int i = 0; i < SIZE; i++) begin
      set_disp(3'(i), 4'(i), 1'b0, 32'd0, 4'd12, 1'b1, 32'(100 + i), 4'd0);
      step();
    end
    set_disp(3'd7, 4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    step();
    check_val("full_occ", 32'(bus.occupancy), SIZE);
    check_val("full_drdy", 32'(bus.disp_ready), 0);
    idle();
    set_cdb(4'd12, 32'h1234);
    step();
    idle();
    for (int k = 0; k < SIZE; k++) begin
      step();
      check_val($sformatf("rr_tag%0d", k), 32'(bus.issue_tag), k);
      if (k == 0) check_val("regrant_drdy", 32'(bus.disp_ready), 1);
    end
    step();

    // pointer at 3 with entries 1 and 5 ready: 5 goes first
    do_flush();
    for (int i = 0; i < SIZE; i++) begin
      set_disp(3'd2, 4'(i), 1'b0, 32'd0,
               (i == 0 || i == 2) ? 4'd13 : ((i == 1 || i == 5) ? 4'd14 : 4'd15),
               1'b1, 32'd9, 4'd0);
      step();
    end
    idle();
    set_cdb(4'd13, 32'hA);
    step();
    idle();
    step();
    check_val("ptr_tag_a", 32'(bus.issue_tag), 0);
    set_cdb(4'd14, 32'hB);
    step();
    check_val("ptr_tag_b", 32'(bus.issue_tag), 2);
    idle();
    step();
    check_val("ptr_tag_c", 32'(bus.issue_tag), 5);
    step();
    check_val("ptr_tag_d", 32'(bus.issue_tag), 1);

    // backpressure
    do_flush();
    bus.issue_ready = 1'b0;
    set_disp(3'd3, 4'd4, 1'b1, 32'h40, 4'd0, 1'b1, 32'h41, 4'd0);
    step();
    set_disp(3'd3, 4'd5, 1'b1, 32'h50, 4'd0, 1'b1, 32'h51, 4'd0);
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("bp_tag", 32'(bus.issue_tag), 4);
      check_val("bp_occ", 32'(bus.occupancy), 1);
    end
    bus.issue_ready = 1'b1;
    step();
    check_val("bp_next_tag", 32'(bus.issue_tag), 5);
    step();

    // flush mid-operation
    do_flush();
    bus.issue_ready = 1'b0;
    set_disp(3'd4, 4'd6, 1'b1, 32'h60, 4'd0, 1'b1, 32'h61, 4'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      set_disp(3'd4, 4'(8 + i), 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
      step();
    end
    check_val("pre_flush_occ", 32'(bus.occupancy), 5);
    set_disp(3'd4, 4'd14, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    bus.flush = 1'b1;
    step();
    check_val("flush_occ", 32'(bus.occupancy), 0);
    check_val("flush_iv", 32'(bus.issue_valid), 0);
    idle();
    step();
    check_val("flush_drop_occ", 32'(bus.occupancy), 0);

    // reset mid-operation
    set_disp(3'd5, 4'd6, 1'b1, 32'h60, 4'd0, 1'b1, 32'h61, 4'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      set_disp(3'd5, 4'(8 + i), 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
      step();
    end
    set_disp(3'd5, 4'd14, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    set_cdb(4'd15, 32'h77);
    rst = 1'b0;
    step();
    check_reset_outputs("midrst");
    rst = 1'b1;
    idle();
    step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.disp_valid  = ($urandom_range(0, 9) < 6);
      bus.disp_op     = 3'($urandom);
      bus.disp_tag    = 4'($urandom);
      bus.disp_v1     = 1'($urandom_range(0, 1));
      bus.disp_v2     = 1'($urandom_range(0, 1));
      bus.disp_r1     = $urandom;
      bus.disp_r2     = $urandom;
      bus.disp_q1     = 4'($urandom_range(0, 3));
      bus.disp_q2     = 4'($urandom_range(0, 3));
      bus.cdb_valid   = ($urandom_range(0, 9) < 4);
      bus.cdb_tag     = 4'($urandom_range(0, 3));
      bus.cdb_data    = $urandom;
      bus.issue_ready = ($urandom_range(0, 9) < 7);
      bus.flush       = ($urandom_range(0, 199) == 0);
      rst             = !($urandom_range(0, 399) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
